// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Upstream ready comes straight from a flop; flush kills the control bits of held entries.
module pipe_stage_skid_reg #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 68
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CTRL_W-1:0] s_ctrl,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CTRL_W-1:0] m_ctrl,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        occupancy
);

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              push, pop;

  // skid_v is only ever set while main_v is set, so the skid slot is always the younger entry
  assign push = s_valid & ~skid_v;
  assign pop  = main_v & m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      // Only the control bits are killed; payload flops keep their last value
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else if (skid_v) begin
      if (pop) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
        skid_v    <= 1'b0;
      end
    end else begin
      if (push && (!main_v || pop)) begin
        main_v    <= 1'b1;
        main_ctrl <= s_ctrl;
        main_data <= s_data;
      end else if (push) begin
        skid_v    <= 1'b1;
        skid_ctrl <= s_ctrl;
        skid_data <= s_data;
      end else if (pop) begin
        main_v    <= 1'b0;
        main_ctrl <= '0;
      end
    end
  end

  assign s_ready   = ~skid_v;
  assign m_valid   = main_v;
  assign m_ctrl    = main_v ? main_ctrl : '0;
  assign m_data    = main_data;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: a queue models held entries, checked every cycle.
module tb_pipe_stage_skid_reg;
  localparam int CTRL_W = 2;
  localparam int DATA_W = 68;
  localparam int EW     = CTRL_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [CTRL_W-1:0] s_ctrl = '0;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic [1:0]        occupancy;

  pipe_stage_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_ctrl(s_ctrl), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_ctrl(m_ctrl), .m_data(m_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  logic [EW-1:0] sb[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("m_valid", 96'(m_valid), 96'(sb.size() > 0));
    check("occupancy", 96'(occupancy), 96'(sb.size()));
    check("s_ready", 96'(s_ready), 96'(sb.size() < 2));
    if (sb.size() == 0) check("m_ctrl_empty", 96'(m_ctrl), 96'(0));
    else check("head", 96'({m_ctrl, m_data}), 96'(sb[0]));
  endtask

  // Drive one cycle's inputs after the falling edge, check mid-cycle, then update the model
  task automatic step(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic mr, input logic fl, output logic acc);
    @(negedge clk);
    s_valid = v; s_ctrl = c; s_data = d; m_ready = mr; flush = fl;
    #1;
    check_state();
    acc = 1'b0;
    if (fl) begin
      sb.delete();
    end else begin
      acc = v && (sb.size() < 2);
      if (mr && sb.size() > 0) void'(sb.pop_front());
      if (acc) sb.push_back({c, d});
    end
  endtask

  logic              acc;
  logic              pend;
  logic              rv, rmr, rfl;
  logic [CTRL_W-1:0] rc;
  logic [DATA_W-1:0] rd;

  initial begin
    // Reset held for three cycles
    repeat (3) @(negedge clk);
    check("rst_m_valid", 96'(m_valid), 96'(0));
    check("rst_m_ctrl", 96'(m_ctrl), 96'(0));
    check("rst_m_data", 96'(m_data), 96'(0));
    check("rst_s_ready", 96'(s_ready), 96'(1));
    check("rst_occupancy", 96'(occupancy), 96'(0));
    rst = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Streaming at one entry per cycle
    for (int i = 1; i <= 3; i++) step(1'b1, 2'b11, DATA_W'(i), 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Back-pressure: third entry held off until the stage drains
    step(1'b1, 2'b01, DATA_W'('hA), 1'b0, 1'b0, acc);
    step(1'b1, 2'b01, DATA_W'('hB), 1'b0, 1'b0, acc);
    step(1'b1, 2'b01, DATA_W'('hC), 1'b0, 1'b0, acc);
    check("bp_m_data", 96'(m_data), 96'('hA));
    check("bp_accept_c", 96'(acc), 96'(0));
    step(1'b1, 2'b01, DATA_W'('hC), 1'b0, 1'b0, acc);
    step(1'b1, 2'b01, DATA_W'('hC), 1'b1, 1'b0, acc);
    step(1'b1, 2'b01, DATA_W'('hC), 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, acc);

    // Flush while full with a concurrent push and pop
    step(1'b1, 2'b10, DATA_W'('hD1), 1'b0, 1'b0, acc);
    step(1'b1, 2'b10, DATA_W'('hD2), 1'b0, 1'b0, acc);
    step(1'b1, 2'b11, DATA_W'('hD3), 1'b1, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Simultaneous push and pop at occupancy 1
    step(1'b1, 2'b01, DATA_W'('h54), 1'b1, 1'b0, acc);
    step(1'b1, 2'b10, DATA_W'('h55), 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Asynchronous reset between clock edges while full
    step(1'b1, 2'b11, DATA_W'('hE1), 1'b0, 1'b0, acc);
    step(1'b1, 2'b11, DATA_W'('hE2), 1'b0, 1'b0, acc);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check("pre_arst_occupancy", 96'(occupancy), 96'(2));
    #1;
    rst = 1'b0;
    #1;
    check("arst_m_valid", 96'(m_valid), 96'(0));
    check("arst_s_ready", 96'(s_ready), 96'(1));
    check("arst_occupancy", 96'(occupancy), 96'(0));
    check("arst_m_ctrl", 96'(m_ctrl), 96'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0, acc);

    // Random traffic; upstream holds an unaccepted entry stable
    pend = 1'b0;
    rv = 1'b0; rc = '0; rd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        rv = 1'($urandom_range(0, 1));
        rc = CTRL_W'($urandom);
        rd = DATA_W'({$urandom, $urandom, $urandom});
      end
      rmr = 1'($urandom_range(0, 1));
      rfl = ($urandom_range(0, 24) == 0);
      step(rv, rc, rd, rmr, rfl, acc);
      pend = rv && !acc && !rfl;
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline stage register, the next generation of the fixed-field stage registers between EXE/MEM/WB. It carries a generic control vector and a generic payload vector with a valid/ready handshake, so downstream stalls back-pressure upstream without combinational ready paths. It uses a 2-entry skid buffer and supports a synchronous flush that kills control bits (WB_en, Mem_R_en, etc.) on branch or hazard.

Parameters:
CTRL_W, 2, width of control field (bits forced to 0 on flush or when the stage is empty)
DATA_W, 68, width of payload field (ALU result, memory value and destination packed by the instantiating stage)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-low (0 = reset asserted)
flush  input  1  synchronous kill of all stage contents
s_valid  input  1  upstream presents an entry
s_ready  output  1  stage can accept an entry (driven directly from a flop)
s_ctrl  input  CTRL_W  upstream control bits
s_data  input  DATA_W  upstream payload
m_valid  output  1  stage holds a valid entry for downstream
m_ready  input  1  downstream accepts the entry
m_ctrl  output  CTRL_W  control bits of the head entry; all 0 whenever m_valid=0
m_data  output  DATA_W  payload of the head entry; holds its last value when m_valid=0
occupancy  output  2  number of held entries (0..2)

Behaviour:
- State: main entry (main_v, main_ctrl, main_data) and skid entry (skid_v, skid_ctrl, skid_data). m_valid=main_v; m_ctrl=main_ctrl gated by main_v; m_data=main_data; s_ready=~skid_v; occupancy=main_v+skid_v.
- Reset (rst=0, asynchronous): main_v=skid_v=0, all ctrl/data flops=0. Outputs during and after reset: m_valid=0, m_ctrl=0, m_data=0, s_ready=1, occupancy=0.
- push = s_valid & s_ready; pop = main_v & m_ready. Transfers occur at the rising edge.
- Priority at each edge: flush first, then the normal update.
- flush=1: main_v<=0, skid_v<=0, main_ctrl<=0, skid_ctrl<=0. Data flops hold. The push and pop of that cycle are discarded. The next cycle shows s_ready=1 and m_valid=0.
- Normal update, skid_v=1 (s_ready=0, so no push): if pop, main<=skid and skid_v<=0; otherwise hold.
- Normal update, skid_v=0:
  - push & (~main_v | pop): main<=input, main_v<=1.
  - push & main_v & ~pop: skid<=input, skid_v<=1. Main holds.
  - ~push & pop: main_v<=0, main_ctrl<=0.
  - Otherwise: hold.
- Latency: an entry accepted at edge N appears on m_* after edge N (1 cycle) when the stage was empty or popping.
- Throughput: 1 entry/cycle when m_ready is held high.
- Order is strictly FIFO. No entry is ever duplicated or lost except through flush.
- Full (occupancy=2): s_ready=0. Upstream must hold s_valid/s_ctrl/s_data stable.
- m_valid, once asserted, stays asserted with stable m_ctrl/m_data until pop or flush.
- No combinational path from m_ready to s_ready.
- Reset asserted mid-transfer: contents are dropped immediately. Behaviour is identical to power-on reset.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, release -> m_valid=0, m_ctrl=0, m_data=0, s_ready=1, occupancy=0.
- Streaming: m_ready=1, push ctrl=2'b11 with data=1,2,3 on consecutive cycles -> m_data=1,2,3 one cycle later each, m_ctrl=2'b11, occupancy=1 throughout, s_ready=1 throughout.
- Back-pressure: m_ready=0, push data=0xA then 0xB -> occupancy=2, s_ready=0, m_data=0xA. A third push of 0xC is held off. Raise m_ready -> outputs 0xA, 0xB, 0xC in order, no loss.
- Flush at full: occupancy=2, assert flush one cycle while s_valid=1 and m_ready=1 -> next cycle m_valid=0, m_ctrl=0, occupancy=0, s_ready=1. The concurrent input is not captured and the concurrent pop is not counted.
- Simultaneous push/pop at occupancy=1: m_ready=1, s_valid=1 with data=0x55 -> m_data=0x55 next cycle, occupancy stays 1, skid never used.
- Async reset mid-operation: occupancy=2, drop rst between edges -> m_valid=0 and s_ready=1 immediately, without waiting for a clock edge.
